// File: rtl/ascii_decimal_parser_pkg.sv
// Package cnc_parse_pkg: shared definitions for the ASCII decimal parser.
//   parse_state_t  : parser FSM states
//   ASC_*          : ASCII character codes recognised by the parser
//   is_terminator  : true for field terminators (space, LF, CR, ';')
//   is_digit       : true for '0'..'9'
package cnc_parse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INT,
        FRAC,
        PAD,
        DONE,
        ERR
    } parse_state_t;

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_NINE  = 8'h39;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SEMI  = 8'h3B;

    function automatic logic is_terminator(input logic [7:0] b);
        return (b == ASC_SPACE) || (b == ASC_LF) || (b == ASC_CR) || (b == ASC_SEMI);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_ZERO) && (b <= ASC_NINE);
    endfunction

endpackage

// File: rtl/ascii_decimal_parser_if.sv
// Byte-stream / result interface of the ASCII decimal parser.
//   i_Byte  : ASCII character            i_Valid : i_Byte valid
//   o_Ready : parser accepts a byte       o_Value : signed fixed-point result
//   o_Done  : 1-cycle completion pulse    o_Error : qualifies o_Done
// Modports: master = byte producer, slave = parser.
interface ascii_decimal_parser_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       i_Byte;
    logic             i_Valid;
    logic             o_Ready;
    logic [WIDTH-1:0] o_Value;
    logic             o_Done;
    logic             o_Error;

    modport master (
        output i_Byte, i_Valid,
        input  o_Ready, o_Value, o_Done, o_Error
    );

    modport slave (
        input  i_Byte, i_Valid,
        output o_Ready, o_Value, o_Done, o_Error
    );
endinterface

// File: rtl/ascii_decimal_parser_mac10.sv
// dec_mac10: one decimal shift step, acc_out = acc_in*10 + digit.
//   acc_in  : current accumulator          digit : BCD digit to append (0 for padding)
//   limit   : largest legal magnitude      acc_out : updated accumulator
//   ovf     : acc_out exceeds limit
module dec_mac10
    import cnc_parse_pkg::*;
#(
    parameter int AW = 36
) (
    input  logic [AW-1:0] acc_in,
    input  logic [3:0]    digit,
    input  logic [AW-1:0] limit,
    output logic [AW-1:0] acc_out,
    output logic          ovf
);
    // acc_in never exceeds limit (< 2^(AW-4)), so *10+9 cannot wrap AW bits.
    always_comb begin
        acc_out = (acc_in << 3) + (acc_in << 1) + AW'(digit);
        ovf     = (acc_out > limit);
    end
endmodule

// File: rtl/ascii_decimal_parser.sv
// ascii_decimal_parser: byte-serial ASCII decimal to signed fixed-point converter.
// Value = round-toward-zero(x * 10^FRAC_DIGITS), two's complement, WIDTH bits.
// Ports:
//   i_Clock50MHz : system clock
//   i_Reset_n    : synchronous reset, active low (priority over everything)
//   i_Clear      : synchronous abort of the field in progress (priority over i_Valid)
//   bus          : ascii_decimal_parser_if.slave (byte in, result out)
// Build option: ASCII_PARSER_SIGN_EN accepts a leading '-'/'+' in IDLE; otherwise
// signs are invalid characters and results are never negative.
module ascii_decimal_parser
    import cnc_parse_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INT_DIGITS  = 5,
    parameter int FRAC_DIGITS = 3
) (
    input  logic                  i_Clock50MHz,
    input  logic                  i_Reset_n,
    input  logic                  i_Clear,
    ascii_decimal_parser_if.slave bus
);
    localparam int AW = WIDTH + 4;
    localparam int IW = $clog2(INT_DIGITS + 2);
    localparam int FW = $clog2(FRAC_DIGITS + 2);

    parse_state_t     state, state_n;
    logic [AW-1:0]    acc, acc_n;
    logic             neg, neg_n;
    logic             have_digit, have_digit_n;
    logic [IW-1:0]    int_cnt, int_cnt_n, int_cnt_inc;
    logic [FW-1:0]    frac_cnt, frac_cnt_n;
    logic [WIDTH-1:0] value_q, value_n;
    logic             done_q, error_q, done_err;
    logic             field_end;

    logic [AW-1:0]    mac_out, limit;
    logic             mac_ovf;
    logic [3:0]       mac_digit;
    logic             ready, hs, is_sign;

    assign ready = (state != PAD) && (state != DONE);
    assign hs    = bus.i_Valid && ready;

`ifdef ASCII_PARSER_SIGN_EN
    assign is_sign = (bus.i_Byte == ASC_MINUS) || (bus.i_Byte == ASC_PLUS);
`else
    assign is_sign = 1'b0;
`endif

    // Magnitude limit: 2^(WIDTH-1)-1, one more when the field is negative.
    always_comb begin
        limit              = '0;
        limit[WIDTH-2:0]   = '1;
        if (neg) limit     = limit + AW'(1);
    end

    // PAD appends implicit trailing zeros; digits map straight from the low nibble.
    assign mac_digit = (state == PAD) ? 4'd0 : bus.i_Byte[3:0];

    dec_mac10 #(.AW(AW)) u_mac (
        .acc_in  (acc),
        .digit   (mac_digit),
        .limit   (limit),
        .acc_out (mac_out),
        .ovf     (mac_ovf)
    );

    // Leading zeros leave acc at 0 and do not count toward INT_DIGITS.
    assign int_cnt_inc = int_cnt + IW'(((acc != '0) || (mac_digit != 4'd0)) ? 1 : 0);

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        neg_n        = neg;
        have_digit_n = have_digit;
        int_cnt_n    = int_cnt;
        frac_cnt_n   = frac_cnt;
        done_err     = 1'b0;
        field_end    = 1'b0;

        unique case (state)
            IDLE, INT: begin
                if (hs) begin
                    if (is_terminator(bus.i_Byte)) begin
                        if (state == INT) field_end = 1'b1;
                    end else if (is_digit(bus.i_Byte)) begin
                        if ((int_cnt_inc > IW'(INT_DIGITS)) || mac_ovf) begin
                            state_n = ERR;
                        end else begin
                            acc_n        = mac_out;
                            int_cnt_n    = int_cnt_inc;
                            have_digit_n = 1'b1;
                            state_n      = INT;
                        end
                    end else if (bus.i_Byte == ASC_DOT) begin
                        state_n = FRAC;
                    end else if (is_sign && (state == IDLE)) begin
                        neg_n   = (bus.i_Byte == ASC_MINUS);
                        state_n = INT;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            FRAC: begin
                if (hs) begin
                    if (is_terminator(bus.i_Byte)) begin
                        field_end = 1'b1;
                    end else if (is_digit(bus.i_Byte)) begin
                        have_digit_n = 1'b1;
                        // Digits past FRAC_DIGITS are truncated (round toward zero).
                        if (frac_cnt < FW'(FRAC_DIGITS)) begin
                            if (mac_ovf) begin
                                state_n = ERR;
                            end else begin
                                acc_n      = mac_out;
                                frac_cnt_n = frac_cnt + FW'(1);
                            end
                        end
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            PAD: begin
                acc_n      = mac_out;
                frac_cnt_n = frac_cnt + FW'(1);
                if (mac_ovf) begin
                    state_n  = DONE;
                    done_err = 1'b1;
                end else if (frac_cnt_n == FW'(FRAC_DIGITS)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n      = IDLE;
                acc_n        = '0;
                neg_n        = 1'b0;
                have_digit_n = 1'b0;
                int_cnt_n    = '0;
                frac_cnt_n   = '0;
            end
            ERR: begin
                if (hs && is_terminator(bus.i_Byte)) begin
                    state_n  = DONE;
                    done_err = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (field_end) begin
            if (!have_digit) begin
                state_n  = DONE;
                done_err = 1'b1;
            end else if (frac_cnt == FW'(FRAC_DIGITS)) begin
                state_n = DONE;
            end else begin
                state_n = PAD;
            end
        end

        if (i_Clear) begin
            state_n      = IDLE;
            acc_n        = '0;
            neg_n        = 1'b0;
            have_digit_n = 1'b0;
            int_cnt_n    = '0;
            frac_cnt_n   = '0;
            done_err     = 1'b0;
        end

        if (done_err) value_n = '0;
        else if (neg) value_n = -acc_n[WIDTH-1:0];
        else          value_n = acc_n[WIDTH-1:0];
    end

    // Result registers load on entry to DONE, so o_Done lines up with the DONE cycle.
    always_ff @(posedge i_Clock50MHz) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            neg        <= 1'b0;
            have_digit <= 1'b0;
            int_cnt    <= '0;
            frac_cnt   <= '0;
            value_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            neg        <= neg_n;
            have_digit <= have_digit_n;
            int_cnt    <= int_cnt_n;
            frac_cnt   <= frac_cnt_n;
            done_q     <= (state_n == DONE);
            if (state_n == DONE) begin
                value_q <= value_n;
                error_q <= done_err;
            end
        end
    end

    assign bus.o_Ready = ready;
    assign bus.o_Value = value_q;
    assign bus.o_Done  = done_q;
    assign bus.o_Error = error_q;

endmodule
